// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic master bus between NREQ
// requesters. A requester keeps the grant while its cyc stays high, and a
// watchdog turns a silent slave into an error after TIMEOUT strobed cycles.
// Every master-side and requester-side output is registered.
module io_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_cyc_i,
  input  logic [NREQ-1:0]      req_stb_i,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [NREQ*DW/8-1:0] req_sel_i,
  input  logic [NREQ*AW-1:0]   req_adr_i,
  input  logic [NREQ*DW-1:0]   req_dat_i,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic [DW-1:0]        req_dat_o,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [DW/8-1:0]      m_sel_o,
  output logic [AW-1:0]        m_adr_o,
  output logic [DW-1:0]        m_dat_o,
  input  logic                 m_ack_i,
  input  logic                 m_err_i,
  input  logic [DW-1:0]        m_dat_i
);

  localparam int SW = DW / 8;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACKW, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gidx;
  logic [TW-1:0]   r_timer;

  logic [IW-1:0]   w_win;
  logic            w_win_vld;
  logic [IW-1:0]   w_src;
  logic            w_cyc_g;
  logic            w_stb_g;
  logic            w_tmo;

  logic [SW-1:0]   w_sel_arr [NREQ];
  logic [AW-1:0]   w_adr_arr [NREQ];
  logic [DW-1:0]   w_dat_arr [NREQ];

  logic [NREQ-1:0] w_gnt_n;
  logic [NREQ-1:0] w_ack_n;
  logic [NREQ-1:0] w_err_n;
  logic [DW-1:0]   w_rdat_n;
  logic            w_cyc_n;
  logic            w_stb_n;
  logic            w_we_n;
  logic [SW-1:0]   w_sel_n;
  logic [AW-1:0]   w_adr_n;
  logic [DW-1:0]   w_mdat_n;
  logic [IW-1:0]   w_last_n;
  logic [IW-1:0]   w_gidx_n;
  logic [TW-1:0]   w_timer_n;
  logic            w_load;
  logic            w_rel;

  for (genvar n = 0; n < NREQ; n++) begin : g_slice
    assign w_sel_arr[n] = req_sel_i[n*SW +: SW];
    assign w_adr_arr[n] = req_adr_i[n*AW +: AW];
    assign w_dat_arr[n] = req_dat_i[n*DW +: DW];
  end

  // Round-robin search starting just after the last served requester;
  // walking backwards lets the nearest candidate overwrite the others.
  always_comb begin : rr_search
    int idx;
    idx       = 0;
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = int'(r_last) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_cyc_i[IW'(idx)]) begin
        w_win     = IW'(idx);
        w_win_vld = 1'b1;
      end
    end
  end

  // In IDLE the fresh winner feeds the master bus, otherwise the held grant.
  assign w_src   = (r_state == S_IDLE) ? w_win : r_gidx;
  assign w_cyc_g = req_cyc_i[r_gidx];
  assign w_stb_g = req_stb_i[r_gidx];
  assign w_tmo   = (r_timer == TW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: slave error beats ack beats timeout beats abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_win_vld) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (m_err_i || m_ack_i || w_tmo) w_state_nxt = S_ACKW;
        else if (!w_cyc_g)               w_state_nxt = S_IDLE;
      end
      S_ACKW: if (!w_stb_g) w_state_nxt = w_cyc_g ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (!w_cyc_g)     w_state_nxt = S_IDLE;
        else if (w_stb_g) w_state_nxt = S_BUSY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of every registered output and bookkeeping reg.
  always_comb begin
    w_gnt_n   = gnt_o;
    w_cyc_n   = m_cyc_o;
    w_stb_n   = m_stb_o;
    w_we_n    = m_we_o;
    w_sel_n   = m_sel_o;
    w_adr_n   = m_adr_o;
    w_mdat_n  = m_dat_o;
    w_ack_n   = '0;
    w_err_n   = '0;
    w_rdat_n  = '0;
    w_last_n  = r_last;
    w_gidx_n  = r_gidx;
    w_timer_n = r_timer;
    w_load    = 1'b0;
    w_rel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_gidx_n  = w_win;
          w_gnt_n   = ONE << w_win;
          w_timer_n = '0;
          w_load    = 1'b1;
        end
      end
      S_BUSY: begin
        if (m_err_i) begin
          w_err_n = gnt_o;
          w_stb_n = 1'b0;
        end else if (m_ack_i) begin
          w_ack_n  = gnt_o;
          w_rdat_n = m_dat_i;
          w_stb_n  = 1'b0;
        end else if (w_tmo) begin
          // A dead slave also loses the cycle so the fabric can recover.
          w_err_n = gnt_o;
          w_stb_n = 1'b0;
          w_cyc_n = 1'b0;
        end else if (!w_cyc_g) begin
          w_rel = 1'b1;
        end else begin
          w_load = 1'b1;
          if (m_stb_o) w_timer_n = r_timer + 1'b1;
        end
      end
      S_ACKW: begin
        if (!w_stb_g && !w_cyc_g) w_rel = 1'b1;
      end
      S_HOLD: begin
        if (!w_cyc_g) begin
          w_rel = 1'b1;
        end else if (w_stb_g) begin
          w_timer_n = '0;
          w_load    = 1'b1;
        end
      end
      default: ;
    endcase
    if (w_load) begin
      w_cyc_n  = 1'b1;
      w_stb_n  = req_stb_i[w_src];
      w_we_n   = req_we_i[w_src];
      w_sel_n  = w_sel_arr[w_src];
      w_adr_n  = w_adr_arr[w_src];
      w_mdat_n = w_dat_arr[w_src];
    end
    if (w_rel) begin
      w_cyc_n  = 1'b0;
      w_stb_n  = 1'b0;
      w_we_n   = 1'b0;
      w_gnt_n  = '0;
      w_last_n = r_gidx;
    end
  end

  // Output and bookkeeping registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_o     <= '0;
      req_ack_o <= '0;
      req_err_o <= '0;
      req_dat_o <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      r_last    <= IW'(NREQ - 1);
      r_gidx    <= '0;
      r_timer   <= '0;
    end else begin
      gnt_o     <= w_gnt_n;
      req_ack_o <= w_ack_n;
      req_err_o <= w_err_n;
      req_dat_o <= w_rdat_n;
      m_cyc_o   <= w_cyc_n;
      m_stb_o   <= w_stb_n;
      m_we_o    <= w_we_n;
      m_sel_o   <= w_sel_n;
      m_adr_o   <= w_adr_n;
      m_dat_o   <= w_mdat_n;
      r_last    <= w_last_n;
      r_gidx    <= w_gidx_n;
      r_timer   <= w_timer_n;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: directed cycle-accurate sequences, a table of
// single accesses, and randomized traffic against a transaction-level model.
module tb_io_bus_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = DW / 8;
  localparam int TMO  = 15;

  logic                 clk_i;
  logic                 rst_i;
  logic [NREQ-1:0]      req_cyc_i, req_stb_i, req_we_i;
  logic [NREQ*SW-1:0]   req_sel_i;
  logic [NREQ*AW-1:0]   req_adr_i;
  logic [NREQ*DW-1:0]   req_dat_i;
  logic [NREQ-1:0]      req_ack_o, req_err_o, gnt_o;
  logic [DW-1:0]        req_dat_o;
  logic                 m_cyc_o, m_stb_o, m_we_o;
  logic [SW-1:0]        m_sel_o;
  logic [AW-1:0]        m_adr_o;
  logic [DW-1:0]        m_dat_o;
  logic                 m_ack_i, m_err_i;
  logic [DW-1:0]        m_dat_i;

  io_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
    .req_sel_i(req_sel_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
    .gnt_o(gnt_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          req;
    logic        we;
    logic [7:0]  sel;
    logic [31:0] adr;
    logic [63:0] wdat;
    logic [63:0] sdat;
    logic [3:0]  exp_gnt;
    int          dly;
    logic        err;
  } vec_t;

  vec_t vt [5];

  // bus-functional slave / requester state
  bit          sl_en, sl_rand, sl_act, sl_err;
  int          sl_dly, sl_cnt, sl_err_pct;
  logic [63:0] sl_dat;
  logic [3:0]  o_gnt, o_ack, o_err, p_cyc;
  logic [63:0] o_dat;
  logic        o_mcyc, o_mstb, o_mwe;
  logic [31:0] o_madr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int n, input logic c, input logic s, input logic w,
                         input logic [SW-1:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_cyc_i[n] = c;
    req_stb_i[n] = s;
    req_we_i[n]  = w;
    req_sel_i[n*SW +: SW] = sel;
    req_adr_i[n*AW +: AW] = a;
    req_dat_i[n*DW +: DW] = d;
  endtask

  task automatic drop_req(input int n);
    req_cyc_i[n] = 1'b0;
    req_stb_i[n] = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_cyc_i = '0; req_stb_i = '0; req_we_i = '0;
    req_sel_i = '0; req_adr_i = '0; req_dat_i = '0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
    sl_act = 1'b0;
    tick();
    chk("rst_gnt",  64'(gnt_o), 0);
    chk("rst_mcyc", 64'(m_cyc_o), 0);
    chk("rst_mstb", 64'(m_stb_o), 0);
    chk("rst_madr", 64'(m_adr_o), 0);
    chk("rst_ack",  64'({req_ack_o, req_err_o}), 0);
    chk("rst_rdat", req_dat_o, 0);
    tick();
    rst_i = 1'b0;
  endtask

  // One clock of bus-functional behaviour: capture outputs, run the slave,
  // and let requesters withdraw once their access has completed.
  task automatic bfm_step();
    tick();
    o_gnt = gnt_o; o_ack = req_ack_o; o_err = req_err_o; o_dat = req_dat_o;
    o_mcyc = m_cyc_o; o_mstb = m_stb_o; o_mwe = m_we_o; o_madr = m_adr_o;
    p_cyc = req_cyc_i;
    if (m_ack_i || m_err_i) begin
      m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0; sl_act = 1'b0;
    end else if (sl_en && o_mcyc && o_mstb) begin
      if (!sl_act) begin sl_act = 1'b1; sl_cnt = 0; end
      if (sl_cnt == sl_dly) begin
        sl_dat = {$urandom(), $urandom()};
        sl_err = ($urandom_range(0, 99) < sl_err_pct);
        if (sl_err) m_err_i = 1'b1; else m_ack_i = 1'b1;
        m_dat_i = sl_dat;
        if (sl_rand) sl_dly = $urandom_range(0, 3);
      end else begin
        sl_cnt++;
      end
    end
    for (int n = 0; n < NREQ; n++)
      if (o_ack[n] || o_err[n]) drop_req(n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq[$];
    logic [3:0] ex4 [4];
    int         ackc [4];
    logic [3:0] prev_gnt, cur_oh, oh;
    int         last_m, exp_w, cur_w, issued, served;
    logic [31:0] radr [4];
    logic        rwe  [4];
    vec_t        v;

    sl_en = 0; sl_rand = 0; sl_err_pct = 0; sl_dly = 0; sl_cnt = 0; sl_err = 0; sl_dat = '0;

    // ---- test 1: single read by requester 0, exact latency ----
    do_reset();
    set_req(0, 1, 1, 0, 8'hFF, 32'hFEE00010, 64'h0);
    tick();                                         // cycle 1
    chk("t1_mcyc", 64'(m_cyc_o), 1);
    chk("t1_madr", 64'(m_adr_o), 64'hFEE00010);
    chk("t1_gnt",  64'(gnt_o), 4'b0001);
    tick();                                         // cycle 2
    tick();                                         // cycle 3
    chk("t1_noack_early", 64'(req_ack_o), 0);
    m_ack_i = 1'b1; m_dat_i = 64'h1122334455667788;
    tick();                                         // cycle 4
    m_ack_i = 1'b0; m_dat_i = '0;
    chk("t1_ack",  64'(req_ack_o), 4'b0001);
    chk("t1_rdat", req_dat_o, 64'h1122334455667788);
    chk("t1_stb_low", 64'(m_stb_o), 0);
    drop_req(0);
    tick();                                         // cycle 5
    chk("t1_ack_pulse", 64'(req_ack_o), 0);
    chk("t1_rdat_zero", req_dat_o, 0);
    chk("t1_idle_cyc",  64'(m_cyc_o), 0);
    chk("t1_idle_gnt",  64'(gnt_o), 0);

    // ---- test 2: four simultaneous requesters rotate fairly ----
    do_reset();
    sl_en = 1; sl_rand = 0; sl_dly = 2; sl_err_pct = 0;
    ex4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int n = 0; n < NREQ; n++) begin
      set_req(n, 1, 1, 0, 8'hFF, 32'h1000 + 32'(n), 64'h0);
      ackc[n] = 0;
    end
    prev_gnt = '0;
    for (int c = 0; c < 80 && req_cyc_i != '0; c++) begin
      bfm_step();
      if (o_gnt != '0 && prev_gnt == '0) gseq.push_back(o_gnt);
      prev_gnt = o_gnt;
      for (int n = 0; n < NREQ; n++) if (o_ack[n]) ackc[n]++;
    end
    chk("t2_grant_count", 64'(gseq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < gseq.size()) chk($sformatf("t2_grant%0d", i), 64'(gseq[i]), 64'(ex4[i]));
    for (int n = 0; n < NREQ; n++) chk($sformatf("t2_acks_req%0d", n), 64'(ackc[n]), 1);
    sl_en = 0;
    repeat (2) tick();

    // ---- table of single accesses ----
    do_reset();
    vt[0] = '{0, 1'b0, 8'hFF, 32'h10000000, 64'h0,                64'hDEADBEEF00000001, 4'b0001, 0, 1'b0};
    vt[1] = '{1, 1'b1, 8'h0F, 32'h20000004, 64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF, 4'b0010, 1, 1'b0};
    vt[2] = '{2, 1'b0, 8'hF0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'b0100, 3, 1'b0};
    vt[3] = '{3, 1'b1, 8'h01, 32'h00000000, 64'h1,                64'h5555555555555555, 4'b1000, 2, 1'b1};
    vt[4] = '{0, 1'b1, 8'h80, 32'h80000000, 64'h8000000000000000, 64'h00000000CAFEF00D, 4'b0001, 0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      v = vt[k];
      set_req(v.req, 1, 1, v.we, v.sel, v.adr, v.wdat);
      tick();
      chk($sformatf("v%0d_gnt", k),  64'(gnt_o), 64'(v.exp_gnt));
      chk($sformatf("v%0d_mcyc", k), 64'(m_cyc_o), 1);
      chk($sformatf("v%0d_mstb", k), 64'(m_stb_o), 1);
      chk($sformatf("v%0d_mwe", k),  64'(m_we_o), 64'(v.we));
      chk($sformatf("v%0d_msel", k), 64'(m_sel_o), 64'(v.sel));
      chk($sformatf("v%0d_madr", k), 64'(m_adr_o), 64'(v.adr));
      chk($sformatf("v%0d_mdat", k), m_dat_o, v.wdat);
      repeat (v.dly) tick();
      if (v.err) m_err_i = 1'b1; else m_ack_i = 1'b1;
      m_dat_i = v.sdat;
      tick();
      m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
      chk($sformatf("v%0d_ack", k),  64'(req_ack_o), v.err ? 64'h0 : 64'(v.exp_gnt));
      chk($sformatf("v%0d_err", k),  64'(req_err_o), v.err ? 64'(v.exp_gnt) : 64'h0);
      chk($sformatf("v%0d_rdat", k), req_dat_o, v.err ? 64'h0 : v.sdat);
      drop_req(v.req);
      tick();
      chk($sformatf("v%0d_pulse", k), 64'({req_ack_o, req_err_o}), 0);
      chk($sformatf("v%0d_release", k), 64'(m_cyc_o), 0);
      tick();
    end

    // ---- test 3: requester 1 locks the bus across two strobes ----
    do_reset();
    set_req(1, 1, 1, 0, 8'hFF, 32'hA1, 64'h0);
    set_req(2, 1, 1, 0, 8'hFF, 32'hA2, 64'h0);
    tick();                                         // cycle 1
    chk("t3_gnt1", 64'(gnt_o), 4'b0010);
    chk("t3_adr1", 64'(m_adr_o), 32'hA1);
    m_ack_i = 1'b1; m_dat_i = 64'h1111;
    tick();                                         // cycle 2
    m_ack_i = 1'b0; m_dat_i = '0;
    chk("t3_ack1", 64'(req_ack_o), 4'b0010);
    chk("t3_dat1", req_dat_o, 64'h1111);
    req_stb_i[1] = 1'b0;
    tick();                                         // cycle 3
    chk("t3_hold_cyc", 64'(m_cyc_o), 1);
    chk("t3_hold_gnt", 64'(gnt_o), 4'b0010);
    set_req(1, 1, 1, 0, 8'hFF, 32'hB1, 64'h0);
    tick();                                         // cycle 4
    chk("t3_stb2", 64'(m_stb_o), 1);
    chk("t3_adr2", 64'(m_adr_o), 32'hB1);
    m_ack_i = 1'b1; m_dat_i = 64'h2222;
    tick();                                         // cycle 5
    m_ack_i = 1'b0; m_dat_i = '0;
    chk("t3_ack2", 64'(req_ack_o), 4'b0010);
    chk("t3_dat2", req_dat_o, 64'h2222);
    req_stb_i[1] = 1'b0;
    tick();                                         // cycle 6
    chk("t3_still_locked", 64'(gnt_o), 4'b0010);
    drop_req(1);
    tick();                                         // cycle 7
    chk("t3_released", 64'(gnt_o), 0);
    tick();                                         // cycle 8
    chk("t3_gnt2", 64'(gnt_o), 4'b0100);
    chk("t3_adr_req2", 64'(m_adr_o), 32'hA2);
    drop_req(2);
    repeat (2) tick();

    // ---- test 4: silent slave triggers the watchdog ----
    do_reset();
    set_req(0, 1, 1, 0, 8'hFF, 32'h44, 64'h0);
    tick();                                         // cycle 1
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("t4_wait_c%0d", c), 64'({req_err_o, m_cyc_o}), 1);
      tick();
    end                                             // cycle 17
    chk("t4_err",  64'(req_err_o), 4'b0001);
    chk("t4_cyc",  64'(m_cyc_o), 0);
    chk("t4_noack", 64'(req_ack_o), 0);
    drop_req(0);
    set_req(2, 1, 1, 0, 8'hFF, 32'h88, 64'h0);
    tick();                                         // cycle 18
    chk("t4_err_pulse", 64'(req_err_o), 0);
    tick();                                         // cycle 19
    chk("t4_rearb", 64'(gnt_o), 4'b0100);
    drop_req(2);
    repeat (2) tick();

    // ---- test 5: requester 3 aborts mid-access; late ack ignored ----
    do_reset();
    set_req(3, 1, 1, 1, 8'hFF, 32'h33, 64'h3);
    tick();                                         // cycle 1
    chk("t5_gnt", 64'(gnt_o), 4'b1000);
    drop_req(3);
    tick();                                         // cycle 2
    chk("t5_cyc_stb_we", 64'({m_cyc_o, m_stb_o, m_we_o}), 0);
    chk("t5_no_resp", 64'({req_ack_o, req_err_o}), 0);
    m_ack_i = 1'b1; m_dat_i = 64'h5A5A;
    tick();                                         // cycle 3
    m_ack_i = 1'b0; m_dat_i = '0;
    chk("t5_late_ack", 64'({req_ack_o, req_err_o}), 0);
    chk("t5_late_dat", req_dat_o, 0);

    // ---- test 6: asynchronous reset while busy ----
    tick();
    set_req(0, 1, 1, 0, 8'hFF, 32'h60, 64'h0);
    tick();
    drop_req(0);
    tick();                                         // req0 served, aborted
    set_req(1, 1, 1, 1, 8'hFF, 32'h61, 64'h6161);
    tick();
    chk("t6_busy", 64'(gnt_o), 4'b0010);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_async_gnt", 64'(gnt_o), 0);
    chk("t6_async_bus", 64'({m_cyc_o, m_stb_o, m_we_o}), 0);
    chk("t6_async_adr", 64'(m_adr_o), 0);
    chk("t6_async_dat", m_dat_o, 0);
    drop_req(1);
    set_req(0, 1, 1, 0, 8'hFF, 32'h70, 64'h0);
    set_req(2, 1, 1, 0, 8'hFF, 32'h72, 64'h0);
    #2;
    rst_i = 1'b0;
    tick();
    chk("t6_tie_gnt", 64'(gnt_o), 4'b0001);
    chk("t6_no_pulse", 64'({req_ack_o, req_err_o}), 0);
    drop_req(0); drop_req(2);
    repeat (3) tick();

    // ---- randomized traffic against a transaction-level model ----
    do_reset();
    sl_en = 1; sl_rand = 1; sl_dly = 1; sl_err_pct = 20;
    last_m = NREQ - 1; cur_w = -1; cur_oh = '0; prev_gnt = '0;
    issued = 0; served = 0;
    for (int n = 0; n < NREQ; n++) begin radr[n] = '0; rwe[n] = 1'b0; end
    for (int c = 0; c < 4000; c++) begin
      bfm_step();
      if (o_gnt != '0 && prev_gnt == '0) begin
        exp_w = -1;
        for (int i = 1; i <= NREQ; i++)
          if (exp_w < 0 && p_cyc[(last_m + i) % NREQ]) exp_w = (last_m + i) % NREQ;
        if (exp_w < 0) begin
          chk("rr_spurious_grant", 64'(o_gnt), 0);
        end else begin
          oh = 4'b0001 << exp_w;
          chk("rr_grant", 64'(o_gnt), 64'(oh));
          last_m = exp_w; cur_w = exp_w; cur_oh = oh;
        end
      end
      prev_gnt = o_gnt;
      if (o_mstb && cur_w >= 0) begin
        chk("rr_madr", 64'(o_madr), 64'(radr[cur_w]));
        chk("rr_mwe",  64'(o_mwe), 64'(rwe[cur_w]));
      end
      if (o_ack != '0 || o_err != '0) begin
        served++;
        chk("rr_resp", 64'({o_err, o_ack}), sl_err ? 64'({cur_oh, 4'b0}) : 64'({4'b0, cur_oh}));
        chk("rr_rdat", o_dat, sl_err ? 64'h0 : sl_dat);
      end
      if (issued < 40) begin
        for (int n = 0; n < NREQ; n++) begin
          if (!p_cyc[n] && !req_cyc_i[n] && $urandom_range(0, 3) == 0) begin
            radr[n] = $urandom();
            rwe[n]  = 1'($urandom_range(0, 1));
            set_req(n, 1, 1, rwe[n], 8'($urandom()), radr[n], {$urandom(), $urandom()});
            issued++;
          end
        end
      end else if (req_cyc_i == '0) begin
        break;
      end
    end
    chk("rr_all_issued_served", 64'(served), 64'(issued));
    chk("rr_drained", 64'(req_cyc_i), 0);
    sl_en = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
